// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one combinational ALU among NUM_REQ
//            requesters; IDLE -> EXEC -> RESP sequencer per operation.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CODE_WIDTH = 3,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*CODE_WIDTH-1:0] req_code,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [DATA_WIDTH-1:0]         alu_in_a,
    output logic [DATA_WIDTH-1:0]         alu_in_b,
    output logic [CODE_WIDTH-1:0]         alu_code,
    input  logic [DATA_WIDTH-1:0]         alu_out,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam logic [ID_WIDTH-1:0] c_last_id = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;
    logic [CODE_WIDTH-1:0] r_op_code;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_hi_found;
    logic [ID_WIDTH-1:0]   w_hi_idx;
    logic                  w_any_found;
    logic [ID_WIDTH-1:0]   w_any_idx;
    logic [ID_WIDTH-1:0]   w_gnt;
    logic [ID_WIDTH-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [NUM_REQ-1:0]    w_own_oh;
    logic                  w_accept;
    logic                  w_capture;

    // Round-robin as two priority searches: lowest valid index at or above
    // rr_ptr, otherwise lowest valid index overall (the wrapped part).
    always_comb begin
        w_hi_found  = 1'b0;
        w_hi_idx    = '0;
        w_any_found = 1'b0;
        w_any_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_any_found = 1'b1;
                w_any_idx   = ID_WIDTH'(k);
                if (ID_WIDTH'(k) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_WIDTH'(k);
                end
            end
        end
    end

    assign w_gnt     = w_hi_found ? w_hi_idx : w_any_idx;
    assign w_ptr_nxt = (w_gnt == c_last_id) ? '0 : (w_gnt + ID_WIDTH'(1));
    assign w_gnt_oh  = NUM_REQ'(1) << w_gnt;
    assign w_own_oh  = NUM_REQ'(1) << r_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rst also gates req_ready so that every output reads zero while in reset.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        resp_valid  = '0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_found && rst) begin
                    req_ready   = w_gnt_oh;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = w_own_oh;
                if (|(resp_ready & w_own_oh)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands are latched at acceptance so requesters may change them freely
    // afterwards without corrupting the in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_op_a    <= req_a[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                r_op_b    <= req_b[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                r_op_code <= req_code[w_gnt*CODE_WIDTH +: CODE_WIDTH];
                r_grant   <= w_gnt;
                r_rr_ptr  <= w_ptr_nxt;
            end
            if (w_capture) begin
                r_result <= alu_out;
            end
        end
    end

    assign alu_in_a  = r_op_a;
    assign alu_in_b  = r_op_b;
    assign alu_code  = r_op_code;
    assign resp_data = r_result;
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// tb_alu_share_arbiter: directed vector table plus hand-written sequences for
// round-robin order, backpressure, wrap-around, reset abort and operand latching.
module tb_alu_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 3;
    localparam int IW = 2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLL  = 3'd5;
    localparam logic [2:0] OP_SRL  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N*CW-1:0]   req_code;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [DW-1:0]     resp_data;
    logic [DW-1:0]     alu_in_a;
    logic [DW-1:0]     alu_in_b;
    logic [CW-1:0]     alu_code;
    logic [DW-1:0]     alu_out;
    logic              busy;
    logic [IW-1:0]     grant_id;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  vmask;
        int          gnt;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  code;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    alu_share_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .CODE_WIDTH (CW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_code   (req_code),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_in_a   (alu_in_a),
        .alu_in_b   (alu_in_b),
        .alu_code   (alu_code),
        .alu_out    (alu_out),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // Shared combinational ALU sitting outside the arbiter.
    always_comb begin
        alu_out = alu_in_a;
        case (alu_code)
            OP_ADD:  alu_out = alu_in_a + alu_in_b;
            OP_SUB:  alu_out = alu_in_a - alu_in_b;
            OP_AND:  alu_out = alu_in_a & alu_in_b;
            OP_OR:   alu_out = alu_in_a | alu_in_b;
            OP_XOR:  alu_out = alu_in_a ^ alu_in_b;
            OP_SLL:  alu_out = alu_in_a << alu_in_b[4:0];
            OP_SRL:  alu_out = alu_in_a >> alu_in_b[4:0];
            default: alu_out = alu_in_a;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] code);
        req_a[id*DW +: DW]    = a;
        req_b[id*DW +: DW]    = b;
        req_code[id*CW +: CW] = code;
    endtask

    // Entered and left at negedge+1 with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [3:0] vmask, input int g,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] code, input logic [31:0] exp);
        set_ops(g, a, b, code);
        req_valid  = vmask;
        resp_ready = '1;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(1) << g);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({tag, " busy_exec"}, 32'(busy), 32'd1);
        chk({tag, " grant_id"}, 32'(grant_id), 32'(g));
        chk({tag, " alu_in_a"}, alu_in_a, a);
        chk({tag, " alu_in_b"}, alu_in_b, b);
        chk({tag, " alu_code"}, 32'(alu_code), 32'(code));
        chk({tag, " resp_valid_exec"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'(1) << g);
        chk({tag, " resp_data"}, resp_data, exp);
        @(negedge clk);
        #1;
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
        chk({tag, " resp_valid_after"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};

        vecs[0] = '{4'b0010, 1, 32'd5,          32'd7,          OP_ADD,  32'd12};
        vecs[1] = '{4'b0100, 2, 32'hF0F0_FF00, 32'hFFFF_0000, OP_AND,  32'hF0F0_0000};
        vecs[2] = '{4'b1000, 3, 32'd10,         32'd3,          OP_SUB,  32'd7};
        vecs[3] = '{4'b0001, 0, 32'd1,          32'd31,         OP_SLL,  32'h8000_0000};
        vecs[4] = '{4'b0010, 1, 32'hFFFF_FFFF, 32'd1,          OP_ADD,  32'd0};
        vecs[5] = '{4'b0100, 2, 32'h8000_0000, 32'd4,          OP_SRL,  32'h0800_0000};
        vecs[6] = '{4'b1000, 3, 32'h0000_1234, 32'd0,          OP_PASS, 32'h0000_1234};
        vecs[7] = '{4'b1111, 0, 32'hA5A5_0000, 32'h0000_5A5A, OP_OR,   32'hA5A5_5A5A};
        vecs[8] = '{4'b1100, 2, 32'hFFFF_0000, 32'h0F0F_0F0F, OP_XOR,  32'hF0F0_0F0F};

        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_code   = '0;

        // Reset state, with all requesters asserting valid.
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst alu_in_a", alu_in_a, 32'd0);
        chk("rst alu_code", 32'(alu_code), 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Round-robin with all four requesters continuously valid.
        for (int i = 0; i < N; i++) set_ops(i, 32'(100 + i), 32'd0, OP_ADD);
        req_valid  = '1;
        resp_ready = '1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("rr req_ready", 32'(req_ready), 32'(1) << rr_exp[n]);
            @(negedge clk);
            #1;
            chk("rr grant_id", 32'(grant_id), 32'(rr_exp[n]));
            @(negedge clk);
            #1;
            chk("rr resp_valid", 32'(resp_valid), 32'(1) << rr_exp[n]);
            chk("rr resp_data", resp_data, 32'(100 + rr_exp[n]));
            @(negedge clk);
            if (n == 4) req_valid = '0;
        end
        #1;
        chk("rr idle", 32'(busy), 32'd0);

        // Operand latching: requester 0 changes A after acceptance (rr_ptr=1).
        set_ops(0, 32'd3, 32'd2, OP_SLL);
        req_valid = 4'b0001;
        #1;
        chk("latch req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid  = '0;
        req_a[31:0] = 32'd9;
        #1;
        chk("latch alu_in_a", alu_in_a, 32'd3);
        @(negedge clk);
        #1;
        chk("latch resp_valid", 32'(resp_valid), 32'd1);
        chk("latch resp_data", resp_data, 32'd12);
        @(negedge clk);
        #1;
        chk("latch idle", 32'(busy), 32'd0);

        // Backpressure on requester 2; other resp_ready bits high and ignored.
        set_ops(2, 32'hF0F0_FF00, 32'hFFFF_0000, OP_AND);
        req_valid  = 4'b0100;
        resp_ready = 4'b1011;
        #1;
        chk("bp req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        chk("bp exec req_ready", 32'(req_ready), 32'd0);
        chk("bp grant_id", 32'(grant_id), 32'd2);
        @(negedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp resp_valid hold", 32'(resp_valid), 32'b0100);
            chk("bp resp_data hold", resp_data, 32'hF0F0_0000);
            chk("bp req_ready hold", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        resp_ready = '1;
        req_valid  = '0;
        #1;
        chk("bp resp_valid last", 32'(resp_valid), 32'b0100);
        @(negedge clk);
        #1;
        chk("bp resp_valid gone", 32'(resp_valid), 32'd0);
        chk("bp idle", 32'(busy), 32'd0);

        // Wrap-around skip: rr_ptr=3, only requester 1 valid; then 1 and 3.
        run_op("wrap1", 4'b0010, 1, 32'h0000_000F, 32'h0000_00F0, OP_OR, 32'h0000_00FF);
        run_op("wrap2", 4'b1010, 3, 32'd7, 32'd5, OP_XOR, 32'd2);

        // Reset during EXEC aborts the operation.
        set_ops(2, 32'd20, 32'd22, OP_ADD);
        req_valid = 4'b0100;
        #1;
        chk("abort req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort resp_valid", 32'(resp_valid), 32'd0);
        chk("abort grant_id", 32'(grant_id), 32'd0);
        chk("abort alu_in_a", alu_in_a, 32'd0);
        chk("abort alu_in_b", alu_in_b, 32'd0);
        chk("abort resp_data", resp_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("abort no resp", 32'(resp_valid), 32'd0);
            chk("abort stays idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        run_op("after_abort", 4'b1111, 0, 32'd55, 32'd0, OP_ADD, 32'd55);

        // Table-driven vectors.
        for (int v = 0; v < 9; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].vmask, vecs[v].gnt, vecs[v].a,
                   vecs[v].b, vecs[v].code, vecs[v].exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
